// File: rtl/flex_counter_ud.sv
// Up/down flex counter with parallel load, one-shot stop and a registered wrap pulse.
// Define FLEX_COUNTER_WRAP_CNT_EN to add the saturating wrap_count output (WRAP_W bits).
module flex_counter_ud #(
    parameter int SIZE = 8
`ifdef FLEX_COUNTER_WRAP_CNT_EN
    ,
    parameter int WRAP_W = 8
`endif
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic            count_enable,
    input  logic            up_down,
    input  logic            oneshot,
    input  logic [SIZE-1:0] rollover_val,
    output logic [SIZE-1:0] count_out,
    output logic            rollover_flag,
    output logic            wrap_pulse
`ifdef FLEX_COUNTER_WRAP_CNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_count
`endif
);

    logic [SIZE-1:0] term_val;
    logic [SIZE-1:0] count_next;
    logic            wrap;
    logic            range_valid;

    assign range_valid = (rollover_val != '0);
    assign term_val    = up_down ? rollover_val : SIZE'(1);

    // Greater/less-or-equal compares let an out-of-range loaded value wrap on the next step.
    always_comb begin
        count_next = count_out;
        wrap       = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_val;
        end else if (count_enable && range_valid) begin
            if (oneshot && (count_out == term_val)) begin
                count_next = count_out;
            end else if (up_down) begin
                if (count_out >= rollover_val) begin
                    count_next = SIZE'(1);
                    wrap       = 1'b1;
                end else begin
                    count_next = count_out + SIZE'(1);
                end
            end else begin
                if (count_out <= SIZE'(1)) begin
                    count_next = rollover_val;
                    wrap       = 1'b1;
                end else begin
                    count_next = count_out - SIZE'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else begin
            count_out     <= count_next;
            rollover_flag <= range_valid && (count_next == term_val);
            wrap_pulse    <= wrap;
        end
    end

`ifdef FLEX_COUNTER_WRAP_CNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wrap_count <= '0;
        end else if (clear) begin
            wrap_count <= '0;
        end else if (wrap && (wrap_count != '1)) begin
            wrap_count <= wrap_count + WRAP_W'(1);
        end
    end
`endif

endmodule
